branch_resolve_ctrl: RTL and testbench

//  Sequences conditional-branch resolution in the pipelined LC-3b core. Maintains the

---
 rtl/branch_resolve_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution for the pipelined LC-3b core. Holds the architectural NZP,
// scoreboards in-flight CC writers, stalls a branch until CC is current, then flushes/redirects.
module branch_resolve_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cc_issue,
    input  logic              cc_wb_valid,
    input  logic [15:0]       cc_wb_value,
    input  logic              br_valid,
    input  logic [2:0]        br_nzp,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              br_done,
    output logic              br_taken,
    output logic [2:0]        cc_q,
    output logic              pend_err
);
    localparam int                PEND_W   = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CC  = 2'd1,
        RESOLVE  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cc_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pend_err_q, pend_err_d;
    logic [2:0]        nzp_q, nzp_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              taken;

    assign taken = |(nzp_q & cc_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cc_d       = cc_q;
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        state_d    = state_q;
        nzp_d      = nzp_q;
        target_d   = target_q;

        if (cc_wb_valid) begin
            if (cc_wb_value == 16'h0000) cc_d = 3'b010;
            else if (cc_wb_value[15])    cc_d = 3'b100;
            else                         cc_d = 3'b001;
        end

        // Issue and writeback together cancel; an out-of-range step is dropped and flagged.
        case ({cc_issue, cc_wb_valid})
            2'b10: begin
                if (pend_q == PEND_MAX) pend_err_d = 1'b1;
                else                    pend_d     = pend_q + PEND_ONE;
            end
            2'b01: begin
                if (pend_q == '0) pend_err_d = 1'b1;
                else              pend_d     = pend_q - PEND_ONE;
            end
            default: ;
        endcase

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    nzp_d    = br_nzp;
                    target_d = br_target;
                    // nzp 000/111 have an outcome independent of CC, so they never wait.
                    if (br_nzp == 3'b000 || br_nzp == 3'b111 || pend_d == '0) state_d = RESOLVE;
                    else                                                      state_d = WAIT_CC;
                end
            end
            WAIT_CC: begin
                // The final writeback lands in cc_q on the same edge that enters RESOLVE.
                if (pend_d == '0) state_d = RESOLVE;
            end
            RESOLVE:  state_d = taken ? REDIRECT : IDLE;
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cc_q       <= 3'b010;
            pend_q     <= '0;
            pend_err_q <= 1'b0;
            nzp_q      <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            cc_q       <= cc_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
            nzp_q      <= nzp_d;
            target_q   <= target_d;
        end
    end

    assign br_ready       = (state_q == IDLE);
    assign stall          = (state_q != IDLE) | br_valid;
    assign flush          = (state_q == RESOLVE) & taken;
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = target_q;
    assign br_done        = ((state_q == RESOLVE) & ~taken) |
                            ((state_q == REDIRECT) & redirect_ready);
    assign br_taken       = (state_q == REDIRECT);
    assign pend_err       = pend_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus randomized branches checked against
// an event-timeline reference model of CC, pending count and branch outcome.
module tb_branch_resolve_ctrl;
    localparam int ADDR_W   = 16;
    localparam int MAX_PEND = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cc_issue;
    logic              cc_wb_valid;
    logic [15:0]       cc_wb_value;
    logic              br_valid;
    logic [2:0]        br_nzp;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              stall;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ready;
    logic              br_done;
    logic              br_taken;
    logic [2:0]        cc_q;
    logic              pend_err;

    branch_resolve_ctrl #(.ADDR_W(ADDR_W), .MAX_PEND(MAX_PEND)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cc_issue       (cc_issue),
        .cc_wb_valid    (cc_wb_valid),
        .cc_wb_value    (cc_wb_value),
        .br_valid       (br_valid),
        .br_nzp         (br_nzp),
        .br_target      (br_target),
        .br_ready       (br_ready),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .br_done        (br_done),
        .br_taken       (br_taken),
        .cc_q           (cc_q),
        .pend_err       (pend_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  m_cc    = 3'b010;
    int          m_pend  = 0;
    bit          m_err   = 1'b0;
    logic [15:0] wb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'h0000)   return 3'b010;
        if ($signed(v) < 0)  return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(2, 0))
            0:       return 16'h0000;
            1:       return 16'h8000 | 16'($urandom);
            default: return 16'($urandom_range(32767, 1));
        endcase
    endfunction

    task automatic set_idle();
        cc_issue       = 1'b0;
        cc_wb_valid    = 1'b0;
        cc_wb_value    = 16'h0000;
        br_valid       = 1'b0;
        br_nzp         = 3'b000;
        br_target      = '0;
        redirect_ready = 1'b0;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then check state.
    task automatic tick();
        int nxt;
        @(posedge clk);
        if (!reset_n) begin
            m_cc   = 3'b010;
            m_pend = 0;
            m_err  = 1'b0;
        end else begin
            if (cc_wb_valid) m_cc = cc_of(cc_wb_value);
            nxt = m_pend + int'(cc_issue) - int'(cc_wb_valid);
            if (nxt < 0 || nxt > MAX_PEND) m_err = 1'b1;
            else                           m_pend = nxt;
        end
        #2;
        check("cc_q", 32'(cc_q), 32'(m_cc));
        check("pend_err", 32'(pend_err), 32'(m_err));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_pend > 0; i++) begin
            set_idle();
            cc_wb_valid = 1'b1;
            cc_wb_value = rand_val();
            tick();
        end
    endtask

    // Issue n CC writers, present one branch, then follow it cycle by cycle to retirement.
    task automatic do_branch(input logic [2:0] nzp, input logic [15:0] tgt,
                             input int n_issue, input int delay);
        int r;
        int hs;
        bit taken;
        bit done;
        bit trivial;
        for (int i = 0; i < n_issue; i++) begin
            set_idle();
            cc_issue = 1'b1;
            tick();
        end
        set_idle();
        br_valid  = 1'b1;
        br_nzp    = nzp;
        br_target = tgt;
        #1;
        check("accept_ready", 32'(br_ready), 32'd1);
        check("accept_stall", 32'(stall), 32'd1);
        tick();
        trivial = (nzp == 3'b000) || (nzp == 3'b111);
        r = -1; hs = -1; taken = 1'b0; done = 1'b0;
        for (int t = 1; t <= 100 && !done; t++) begin
            set_idle();
            if (r < 0 && (trivial || m_pend == 0)) begin
                r     = t;
                taken = |(nzp & m_cc);
                hs    = taken ? t + 1 + delay : t;
            end
            if (m_pend > 0 && (wb_q.size() > 0 || $urandom_range(1, 0) == 1)) begin
                cc_wb_valid = 1'b1;
                cc_wb_value = (wb_q.size() > 0) ? wb_q.pop_front() : rand_val();
            end
            redirect_ready = (r >= 0) && taken && (t == hs);
            #1;
            check("flush", 32'(flush), 32'(t == r && taken));
            check("br_done", 32'(br_done), 32'(t == hs));
            if (t == hs) begin
                check("br_taken", 32'(br_taken), 32'(taken));
                done = 1'b1;
            end
            check("redirect_valid", 32'(redirect_valid), 32'(r >= 0 && taken && t > r && t <= hs));
            if (redirect_valid) check("redirect_pc", 32'(redirect_pc), 32'(tgt));
            check("busy_stall", 32'(stall), 32'd1);
            check("busy_ready", 32'(br_ready), 32'd0);
            tick();
        end
        check("br_retired", 32'(done), 32'd1);
        set_idle();
        #1;
        check("post_stall", 32'(stall), 32'd0);
        check("post_ready", 32'(br_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_ready", 32'(br_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
        check("rst_br_done", 32'(br_done), 32'd0);
        check("rst_br_taken", 32'(br_taken), 32'd0);

        // 1: CC negative, BR n with nothing pending -> taken, flush, redirect.
        set_idle(); cc_issue = 1'b1; tick();
        set_idle(); cc_wb_valid = 1'b1; cc_wb_value = 16'h8000; tick();
        do_branch(3'b100, 16'h1234, 0, 0);

        // 2: two writers in flight, BR z waits; last writeback 0x0005 makes it not taken.
        wb_q.push_back(16'h0000);
        wb_q.push_back(16'h0005);
        do_branch(3'b010, 16'h2222, 2, 0);
        wb_q.delete();
        drain();

        // 3: BR nzp=111 with two pending resolves without waiting; fetch stalls three cycles.
        do_branch(3'b111, 16'hABCD, 2, 3);
        drain();

        // 4: BR nzp=000 with the scoreboard full retires not-taken immediately.
        do_branch(3'b000, 16'h5555, 3, 0);
        drain();

        for (int k = 0; k < 40; k++) begin
            set_idle();
            cc_issue    = 1'b1;
            cc_wb_valid = 1'b1;
            cc_wb_value = rand_val();
            tick();
            do_branch(3'($urandom_range(7, 0)), 16'($urandom), $urandom_range(3, 0),
                      $urandom_range(4, 0));
            drain();
        end

        // 5: simultaneous issue/writeback holds the count; underflow sets a sticky error.
        set_idle(); cc_issue = 1'b1; tick();
        set_idle(); cc_issue = 1'b1; cc_wb_valid = 1'b1; cc_wb_value = 16'h0007; tick();
        set_idle(); cc_wb_valid = 1'b1; cc_wb_value = 16'h8001; tick();
        set_idle(); cc_wb_valid = 1'b1; cc_wb_value = 16'h0000; tick();
        set_idle(); tick(); tick();
        do_branch(3'b010, 16'h0F0F, 0, 1);

        // 6: reset in REDIRECT drops the redirect and clears CC, count and error.
        set_idle(); cc_issue = 1'b1; cc_wb_valid = 1'b1; cc_wb_value = 16'hF000; tick();
        set_idle(); cc_issue = 1'b1; tick();
        set_idle(); cc_issue = 1'b1; tick();
        set_idle(); br_valid = 1'b1; br_nzp = 3'b111; br_target = 16'hBEEF; tick();
        set_idle(); #1;
        check("t6_flush", 32'(flush), 32'd1);
        tick();
        set_idle(); #1;
        check("t6_redirect_valid", 32'(redirect_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_idle(); #1;
        check("t6_redirect_dropped", 32'(redirect_valid), 32'd0);
        check("t6_ready", 32'(br_ready), 32'd1);
        check("t6_stall", 32'(stall), 32'd0);
        check("t6_flush_after", 32'(flush), 32'd0);
        check("t6_br_done", 32'(br_done), 32'd0);
        for (int i = 0; i < MAX_PEND + 1; i++) begin
            set_idle();
            cc_issue = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
